// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package bcd_timer_pkg;

    // Timer control states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPLODED = 2'd3
    } timer_state_t;

    // Largest legal value of a decimal digit and of the tens-of-seconds digit.
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] SEC_TEN_MAX = 4'd5;

    // Widest time bus supported: four minute digits plus two second digits.
    localparam int MAX_TIME_W = 24;

    // A time value is legal when both second digits and every used minute digit
    // are within range. Narrower buses are zero-extended by the caller, so
    // unused upper nibbles are zero and never affect the result.
    function automatic logic is_valid_bcd_time(input logic [MAX_TIME_W-1:0] t,
                                               input int min_digits);
        logic ok;
        ok = 1'b1;
        if (t[3:0] > BCD_MAX) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        if (t[7:4] > SEC_TEN_MAX) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        for (int i = 0; i < 4; i++) begin
            if ((i < min_digits) && (t[8 + 4*i +: 4] > BCD_MAX)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement ripple chain: subtracts the incoming borrow
// and wraps 0 to MODULUS_MAX, passing a borrow to the next digit up.
module bcd_digit_dec
    import bcd_timer_pkg::*;
#(
    parameter logic [3:0] MODULUS_MAX = 4'd9
) (
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    // Decrement with wrap; without an incoming borrow the digit passes through.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = MODULUS_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_next = digit;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown_core.sv
// MM:SS countdown core: BCD time register, sub-second tick divider with
// strike speed-up, pause, load validation and a sticky explode flag.
module bcd_countdown_core
    import bcd_timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter int SUBTICKS   = 4,
    parameter int STRIKE_W   = 2,
    parameter int W          = 4 * (MIN_DIGITS + 2)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick_enable,
    input  logic                load,
    input  logic [W-1:0]        time_count,
    input  logic                stop,
    input  logic [STRIKE_W-1:0] strikes,
    output logic [W-1:0]        bcd,
    output logic                running,
    output logic                explode,
    output logic                load_err,
    output logic                low_time
);

    localparam int NDIG  = MIN_DIGITS + 2;
    localparam int CNT_W = 5;
    // Threshold arithmetic is wide enough for both the counter and any strike count.
    localparam int TW    = ((STRIKE_W > CNT_W) ? STRIKE_W : CNT_W) + 1;
    localparam logic [TW-1:0] SUB_T = TW'(SUBTICKS);
    localparam logic [TW-1:0] ONE_T = TW'(1);

    timer_state_t     state_r;
    logic [W-1:0]     bcd_r;
    logic             explode_r;
    logic             load_err_r;
    logic [CNT_W-1:0] sub_cnt_r;

    logic [W-1:0]     dec_bcd_s;
    logic [NDIG:0]    borrow_s;
    logic             bcd_zero_s;
    logic             load_valid_s;
    logic             time_zero_s;
    logic [TW-1:0]    strikes_ext_s;
    logic [TW-1:0]    thr_s;
    logic             boundary_s;

    // The chain always subtracts one second; the result is only used at a boundary.
    assign borrow_s[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_dec
            localparam logic [3:0] DIG_MAX = (g == 1) ? SEC_TEN_MAX : BCD_MAX;
            bcd_digit_dec #(.MODULUS_MAX(DIG_MAX)) u_dec (
                .digit      (bcd_r[4*g +: 4]),
                .borrow_in  (borrow_s[g]),
                .digit_next (dec_bcd_s[4*g +: 4]),
                .borrow_out (borrow_s[g+1])
            );
        end
    endgenerate

    // A borrow escaping the top digit happens exactly when every digit is zero.
    assign bcd_zero_s = borrow_s[NDIG];

    // Load qualification: digit ranges and the zero special case.
    always_comb begin
        load_valid_s = is_valid_bcd_time(MAX_TIME_W'(time_count), MIN_DIGITS);
        time_zero_s  = (time_count == {W{1'b0}});
    end

    // Ticks per second shrink with strikes but never below one; re-evaluated
    // every cycle so a strike jump past the current count forces the next boundary.
    always_comb begin
        strikes_ext_s = TW'(strikes);
        if (strikes_ext_s >= SUB_T) begin
            thr_s = ONE_T;
        end else begin
            thr_s = SUB_T - strikes_ext_s;
        end
        boundary_s = ((TW'(sub_cnt_r) + ONE_T) >= thr_s);
    end

    // Control FSM with registered time, flag and error outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            bcd_r      <= {W{1'b0}};
            explode_r  <= 1'b0;
            load_err_r <= 1'b0;
            sub_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            load_err_r <= 1'b0;
            if (load) begin
                if (!load_valid_s) begin
                    load_err_r <= 1'b1;
                end else if (time_zero_s) begin
                    state_r   <= ST_EXPLODED;
                    bcd_r     <= {W{1'b0}};
                    explode_r <= 1'b1;
                    sub_cnt_r <= {CNT_W{1'b0}};
                end else begin
                    state_r   <= stop ? ST_PAUSED : ST_RUN;
                    bcd_r     <= time_count;
                    explode_r <= 1'b0;
                    sub_cnt_r <= {CNT_W{1'b0}};
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_r <= ST_PAUSED;
                        end else if (tick_enable) begin
                            if (boundary_s) begin
                                sub_cnt_r <= {CNT_W{1'b0}};
                                if (bcd_zero_s) begin
                                    state_r   <= ST_EXPLODED;
                                    explode_r <= 1'b1;
                                end else begin
                                    bcd_r <= dec_bcd_s;
                                end
                            end else begin
                                sub_cnt_r <= sub_cnt_r + 5'd1;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_PAUSED: begin
                        if (!stop) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_PAUSED;
                        end
                    end
                    ST_EXPLODED: begin
                        bcd_r     <= {W{1'b0}};
                        explode_r <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bcd      = bcd_r;
    assign explode  = explode_r;
    assign load_err = load_err_r;
    assign running  = (state_r == ST_RUN) || (state_r == ST_PAUSED);
    assign low_time = running && (bcd_r[W-1:8] == {(W-8){1'b0}});

endmodule

// File: tb/tb_bcd_countdown_core.sv
// Scoreboard bench for bcd_countdown_core (2 minute digits, 4 subticks).
module tb_bcd_countdown_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick_enable;
    logic        load;
    logic [15:0] time_count;
    logic        stop;
    logic [1:0]  strikes;
    logic [15:0] bcd;
    logic        running;
    logic        explode;
    logic        load_err;
    logic        low_time;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        running;
        logic        explode;
        logic        load_err;
        logic        low_time;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_m;

    bcd_countdown_core #(.MIN_DIGITS(2), .SUBTICKS(4), .STRIKE_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .tick_enable (tick_enable),
        .load        (load),
        .time_count  (time_count),
        .stop        (stop),
        .strikes     (strikes),
        .bcd         (bcd),
        .running     (running),
        .explode     (explode),
        .load_err    (load_err),
        .low_time    (low_time)
    );

    always #5 clock = ~clock;

    // Monitor: pops one expectation per falling edge and compares all outputs.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur_m = exp_q.pop_front();
            checks = checks + 1;
            if (bcd !== cur_m.bcd || running !== cur_m.running || explode !== cur_m.explode ||
                load_err !== cur_m.load_err || low_time !== cur_m.low_time) begin
                errors = errors + 1;
                $display("FAIL %s: got bcd=%h running=%b explode=%b load_err=%b low_time=%b, want bcd=%h running=%b explode=%b load_err=%b low_time=%b",
                         cur_m.tag, bcd, running, explode, load_err, low_time,
                         cur_m.bcd, cur_m.running, cur_m.explode, cur_m.load_err, cur_m.low_time);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input logic [15:0] b, input logic r, input logic e,
                              input logic le, input logic lt, input string tag);
        exp_t x;
        x.bcd = b; x.running = r; x.explode = e; x.load_err = le; x.low_time = lt; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic do_load(input logic [15:0] v);
        time_count = v;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_enable = 1'b1;
        repeat (n) cycle();
        tick_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_enable = 1'b0; load = 1'b0; time_count = 16'h0000;
        stop = 1'b0; strikes = 2'd0;
        cycle();
        expect_out(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");
        reset = 1'b0;
        cycle();

        // Normal countdown from 01:30
        do_load(16'h0130);  expect_out(16'h0130, 1'b1, 1'b0, 1'b0, 1'b0, "load_0130");
        ticks(4);           expect_out(16'h0129, 1'b1, 1'b0, 1'b0, 1'b0, "after_4_ticks");
        ticks(36);          expect_out(16'h0120, 1'b1, 1'b0, 1'b0, 1'b0, "after_40_ticks");
        ticks(80);          expect_out(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, "minute_edge");
        ticks(4);           expect_out(16'h0059, 1'b1, 1'b0, 1'b0, 1'b1, "minute_borrow_low_time");

        // Expiry: 2 s loaded explodes on tick 12
        do_load(16'h0002);  expect_out(16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, "load_0002");
        ticks(11);          expect_out(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, "tick_11_no_explode");
        ticks(1);           expect_out(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "tick_12_explode");
        ticks(20);          expect_out(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "explode_sticky");

        // Invalid load in EXPLODED: error pulse, nothing else moves
        do_load(16'h0075);  expect_out(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, "bad_load_err");
        cycle();            expect_out(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "load_err_one_cycle");

        // Strike speed-up
        strikes = 2'd2;
        do_load(16'h1000);  expect_out(16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, "load_1000_leaves_exploded");
        ticks(2);           expect_out(16'h0959, 1'b1, 1'b0, 1'b0, 1'b0, "thr2_decrement");
        strikes = 2'd3;
        ticks(1);           expect_out(16'h0958, 1'b1, 1'b0, 1'b0, 1'b0, "thr1_tick_a");
        ticks(1);           expect_out(16'h0957, 1'b1, 1'b0, 1'b0, 1'b0, "thr1_tick_b");
        strikes = 2'd0;
        ticks(2);           expect_out(16'h0957, 1'b1, 1'b0, 1'b0, 1'b0, "thr4_partial");
        strikes = 2'd3;
        ticks(1);           expect_out(16'h0956, 1'b1, 1'b0, 1'b0, 1'b0, "counter_above_thr");
        strikes = 2'd0;

        // Zero load explodes immediately
        do_load(16'h0000);  expect_out(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "zero_load");

        // Pause holds the count
        do_load(16'h0500);  expect_out(16'h0500, 1'b1, 1'b0, 1'b0, 1'b0, "load_0500");
        stop = 1'b1;
        ticks(100);         expect_out(16'h0500, 1'b1, 1'b0, 1'b0, 1'b0, "stop_hold");
        stop = 1'b0;
        cycle();
        ticks(4);           expect_out(16'h0459, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
        stop = 1'b1;
        do_load(16'h0010);  expect_out(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, "load_paused");
        ticks(8);           expect_out(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, "paused_hold");
        stop = 1'b0;
        cycle();
        ticks(4);           expect_out(16'h0009, 1'b1, 1'b0, 1'b0, 1'b1, "paused_resume");

        // Load beats a coincident boundary tick and clears the subtick counter
        do_load(16'h0500);
        ticks(3);           expect_out(16'h0500, 1'b1, 1'b0, 1'b0, 1'b0, "pre_boundary");
        time_count = 16'h0300; load = 1'b1; tick_enable = 1'b1;
        cycle();
        load = 1'b0; tick_enable = 1'b0;
                            expect_out(16'h0300, 1'b1, 1'b0, 1'b0, 1'b0, "load_wins_tick");
        ticks(3);           expect_out(16'h0300, 1'b1, 1'b0, 1'b0, 1'b0, "counter_cleared");
        ticks(1);           expect_out(16'h0259, 1'b1, 1'b0, 1'b0, 1'b0, "first_second_after_load");

        // Reset mid-count overrides a simultaneous load
        ticks(2);
        reset = 1'b1; time_count = 16'h0400; load = 1'b1;
        cycle();
        reset = 1'b0; load = 1'b0;
                            expect_out(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_count");
        do_load(16'h0000);  expect_out(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "explode_before_reset");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
                            expect_out(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset_clears_explode");
        ticks(8);           expect_out(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "idle_ignores_ticks");

        cycle();
        cycle();
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue: %0d expectations never compared", exp_q.size());
        end
        if (checks < 12) begin
            errors = errors + 1;
            $display("FAIL coverage: only %0d checks ran", checks);
        end
        if (errors == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
